mac_requant_drain: RTL and testbench

- Downstream stage of the MAC: watches the MAC control strobes, counts accumulation terms per neuron, and captures the final 16-bit accumulator once the last term has landed.
- Applies optional ReLU, a rounding arithmetic right shift and int8 saturation.
- Queues each int8 activation, tagged with a neuron index, in a small FIFO with a valid/ready interface toward the next-layer input buffer or the argmax stage.

---
 rtl/npu_pkg.sv | 38 +++
 rtl/mac_requant_drain_if.sv | 27 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/mac_requant_drain.sv | 96 +++++++++
 tb/tb_mac_requant_drain.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/npu_pkg.sv
// Shared numeric types, int8 limits and the requantisation rule for the NPU datapath.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package npu_pkg;

    localparam int ACC_W = 16;
    localparam int ACT_W = 8;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [ACT_W-1:0] act_t;
    // One bit of headroom so the rounding offset can never wrap the accumulator.
    typedef logic signed [ACC_W:0]   acc_ext_t;

    localparam act_t INT8_MAX = act_t'(8'h7f);
    localparam act_t INT8_MIN = act_t'(8'h80);

    // Optional ReLU, then round-half-up arithmetic right shift, then int8 saturation.
    function automatic act_t requant(input acc_t acc, input logic [3:0] shift, input logic relu);
        acc_ext_t v;
        acc_ext_t rnd;
        v = acc_ext_t'(acc);
        if (relu && acc[ACC_W-1]) begin
            v = '0;
        end
        if (shift != 4'd0) begin
            rnd = acc_ext_t'(1) <<< (shift - 4'd1);
            v   = v + rnd;
            v   = v >>> shift;
        end
        if (v > acc_ext_t'(INT8_MAX)) begin
            return INT8_MAX;
        end else if (v < acc_ext_t'(INT8_MIN)) begin
            return INT8_MIN;
        end
        return v[ACT_W-1:0];
    endfunction

endpackage

// File: rtl/mac_requant_drain_if.sv
// Activation stream from the requant drain toward the next-layer buffer or argmax.
// Latency: none (wires only).
// Backpressure: consumer holds out_ready low; head stays stable while out_valid is high.
interface mac_requant_drain_if #(
    parameter int IDX_W = 8
);
    npu_pkg::act_t    out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_valid;
    logic             out_ready;

    // Producer side: the drain stage.
    modport master (
        output out_data,
        output out_idx,
        output out_valid,
        input  out_ready
    );

    // Consumer side: next-layer input buffer or argmax stage.
    modport slave (
        input  out_data,
        input  out_idx,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO; head is combinationally visible, no fall-through.
// Latency: a pushed entry appears at the head one cycle after the push.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Extra MSB on each pointer tells a full ring from an empty one.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees a slot in the same cycle, so a push at full still lands.
    assign do_push = push && (!full || do_pop);

    // Empty FIFO presents zeros rather than stale storage.
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/mac_requant_drain.sv
// Counts MAC terms per neuron, captures the final accumulator, requantises to int8 and queues it with an index tag.
// Latency: out_valid rises 2 cycles after the last term cycle (FIFO previously empty).
// Backpressure: out_ready stalls the FIFO head; a result arriving at a full FIFO with no pop is dropped and sets sticky overflow.
module mac_requant_drain import npu_pkg::*; #(
    parameter int N_TERMS = 784,
    parameter int DEPTH   = 4,
    parameter int IDX_W   = 8
) (
    input  logic                    CLKEXT,
    input  logic                    RST_ACT,
    input  logic                    EN_MAC,
    input  logic                    RST_MAC,
    input  acc_t                    mac_result,
    input  logic [3:0]              shift,
    input  logic                    relu_en,
    mac_requant_drain_if.master     out_if,
    output logic                    overflow
);
    localparam int                CNT_W    = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N_TERMS - 1);
    localparam int                ENT_W    = IDX_W + ACT_W;

    logic [CNT_W-1:0] cnt;
    logic             last_term;
    logic             cap_pend;
    logic [IDX_W-1:0] idx;
    act_t             cap_act;
    logic [ENT_W-1:0] push_dat;
    logic [ENT_W-1:0] head_dat;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    // The cycle in which the final term of the current neuron is accumulated.
    assign last_term = EN_MAC && !RST_MAC && (cnt == LAST_CNT);

    // Term counter and capture request; RST_MAC discards a partial neuron but never a pending capture.
    always_ff @(posedge CLKEXT) begin
        if (RST_ACT) begin
            cnt      <= '0;
            cap_pend <= 1'b0;
        end else begin
            cap_pend <= last_term;
            if (RST_MAC) begin
                cnt <= '0;
            end else if (EN_MAC) begin
                cnt <= last_term ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    // Capture stage: the MAC register shows the final sum one cycle after the last term,
    // so shift/relu_en are sampled with it and the requantised value is written straight
    // into the FIFO at the end of that cycle; the FIFO entry acts as the capture register.
    assign cap_act  = requant(mac_result, shift, relu_en);
    assign push_dat = {idx, cap_act};

    // Neuron index advances on every completed neuron, dropped or not, so gaps reveal losses.
    always_ff @(posedge CLKEXT) begin
        if (RST_ACT) begin
            idx <= '0;
        end else if (cap_pend) begin
            idx <= idx + IDX_W'(1);
        end
    end

    // Sticky drop flag: a completed neuron found the FIFO full with no pop to make room.
    always_ff @(posedge CLKEXT) begin
        if (RST_ACT) begin
            overflow <= 1'b0;
        end else if (cap_pend && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    assign pop = out_if.out_valid && out_if.out_ready;

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLKEXT),
        .rst       (RST_ACT),
        .push      (cap_pend),
        .push_data (push_dat),
        .pop       (pop),
        .pop_data  (head_dat),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_if.out_valid = !fifo_empty;
    assign out_if.out_idx   = head_dat[ENT_W-1:ACT_W];
    assign out_if.out_data  = head_dat[ACT_W-1:0];

endmodule

// File: tb/tb_mac_requant_drain.sv
// Randomised scoreboard bench for mac_requant_drain with N_TERMS=4, DEPTH=4.
// Latency: checks cycle-exact out_valid timing against a queue model.
// Backpressure: out_ready driven low, high or randomly per phase.
module tb_mac_requant_drain;
    localparam int N_TERMS = 4;
    localparam int DEPTH   = 4;
    localparam int IDX_W   = 8;

    typedef struct {
        int data;
        int idx;
    } ent_t;

    logic               CLKEXT = 1'b0;
    logic               RST_ACT;
    logic               EN_MAC;
    logic               RST_MAC;
    logic signed [15:0] mac_result;
    logic [3:0]         shift;
    logic               relu_en;
    logic               overflow;

    mac_requant_drain_if #(.IDX_W(IDX_W)) ifc ();

    mac_requant_drain #(
        .N_TERMS (N_TERMS),
        .DEPTH   (DEPTH),
        .IDX_W   (IDX_W)
    ) dut (
        .CLKEXT     (CLKEXT),
        .RST_ACT    (RST_ACT),
        .EN_MAC     (EN_MAC),
        .RST_MAC    (RST_MAC),
        .mac_result (mac_result),
        .shift      (shift),
        .relu_en    (relu_en),
        .out_if     (ifc),
        .overflow   (overflow)
    );

    always #5 CLKEXT = ~CLKEXT;

    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 0;
    int   rmode  = 1;
    int   drain_req  = 0;
    int   drain_seen = 0;
    bit   drain_ok   = 1;

    // Reference model state: contents of the output queue as the specification defines them.
    ent_t mq[$];
    int   m_cnt   = 0;
    bit   m_pend  = 0;
    int   m_idx   = 0;
    bit   m_ovf   = 0;
    bit   m_just_rst = 0;
    ent_t m_e;
    bit   m_pop;
    bit   m_push;

    function automatic int ref_requant(int acc, int sh, bit relu);
        int v;
        v = acc;
        if (relu && v < 0) v = 0;
        if (sh > 0) v = (v + (1 << (sh - 1))) >>> sh;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v;
    endfunction

    // Model: one completed neuron per N_TERMS enabled cycles, captured the cycle after.
    always @(posedge CLKEXT) begin
        if (RST_ACT) begin
            mq.delete();
            m_cnt = 0;
            m_pend = 0;
            m_idx = 0;
            m_ovf = 0;
            m_just_rst = 1;
        end else begin
            m_just_rst = 0;
            m_pop  = (mq.size() > 0) && ifc.out_ready;
            m_push = 0;
            if (m_pend) begin
                m_e.data = ref_requant(int'(mac_result), int'(shift), relu_en);
                m_e.idx  = m_idx;
                m_idx    = (m_idx + 1) % (1 << IDX_W);
                if (mq.size() == DEPTH && !m_pop) m_ovf = 1;
                else m_push = 1;
            end
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(m_e);
            m_pend = EN_MAC && !RST_MAC && (m_cnt == N_TERMS - 1);
            if (RST_MAC) m_cnt = 0;
            else if (EN_MAC) m_cnt = m_pend ? 0 : m_cnt + 1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs with the model away from the active edge.
    always @(negedge CLKEXT) begin
        if (mon_en) begin
            chk("out_valid", int'(ifc.out_valid), int'(mq.size() > 0));
            chk("overflow", int'(overflow), int'(m_ovf));
            if (m_just_rst) begin
                chk("reset_out_data", int'(ifc.out_data), 0);
                chk("reset_out_idx", int'(ifc.out_idx), 0);
            end
            if (ifc.out_valid && ifc.out_ready && mq.size() > 0) begin
                chk("out_data", int'(ifc.out_data), mq[0].data);
                chk("out_idx", int'(ifc.out_idx), mq[0].idx);
            end
            if (drain_req != drain_seen) begin
                drain_seen = drain_req;
                chk("drain_done", int'(drain_ok), 1);
            end
        end
    end

    task automatic cyc();
        if (rmode == 0) ifc.out_ready = 1'b0;
        else if (rmode == 1) ifc.out_ready = 1'b1;
        else ifc.out_ready = ($urandom_range(0, 3) != 0);
        @(posedge CLKEXT);
        #1;
    endtask

    task automatic do_reset();
        RST_ACT = 1'b1;
        cyc();
        RST_ACT = 1'b0;
    endtask

    task automatic partial(input int n);
        EN_MAC = 1'b0;
        RST_MAC = 1'b1;
        cyc();
        RST_MAC = 1'b0;
        for (int k = 0; k < n; k++) begin
            EN_MAC = 1'b1;
            mac_result = 16'($urandom);
            cyc();
        end
        EN_MAC = 1'b0;
    endtask

    task automatic neuron(input int fin, input int sh, input bit relu, input bit rst_pulse,
                          input bit gaps, input bit en_cap, input bit rm_cap, input bit ract_cap,
                          input int rmode_cap);
        if (rst_pulse) begin
            EN_MAC = 1'b0;
            RST_MAC = 1'b1;
            mac_result = 16'($urandom);
            cyc();
            RST_MAC = 1'b0;
        end
        for (int k = 0; k < N_TERMS; k++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    EN_MAC = 1'b0;
                    mac_result = 16'($urandom);
                    cyc();
                end
            end
            EN_MAC = 1'b1;
            mac_result = 16'($urandom);
            shift = 4'($urandom);
            relu_en = 1'($urandom);
            cyc();
        end
        EN_MAC = en_cap;
        RST_MAC = rm_cap;
        RST_ACT = ract_cap;
        mac_result = 16'(fin);
        shift = 4'(sh);
        relu_en = relu;
        if (rmode_cap >= 0) rmode = rmode_cap;
        cyc();
        EN_MAC = 1'b0;
        RST_MAC = 1'b0;
        RST_ACT = 1'b0;
        mac_result = 16'($urandom);
        shift = 4'($urandom);
        relu_en = 1'($urandom);
    endtask

    task automatic drain();
        rmode = 1;
        for (int k = 0; k < 60 && mq.size() > 0; k++) cyc();
        cyc();
        drain_ok = (mq.size() == 0);
        drain_req++;
        cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fin;
        RST_ACT = 1'b1;
        EN_MAC = 1'b0;
        RST_MAC = 1'b0;
        mac_result = '0;
        shift = '0;
        relu_en = 1'b0;
        ifc.out_ready = 1'b0;
        rmode = 1;
        cyc();
        cyc();
        mon_en = 1;
        RST_ACT = 1'b0;

        // Directed requant values and the 2-cycle latency.
        neuron(336, 2, 1, 1, 0, 0, 0, 0, -1);
        cyc();
        cyc();
        neuron(-200, 0, 0, 0, 0, 0, 0, 0, -1);
        neuron(-200, 0, 1, 0, 1, 0, 0, 0, -1);
        neuron(6, 2, 0, 1, 0, 0, 0, 0, -1);
        neuron(5, 1, 0, 0, 1, 0, 1, 0, -1);
        neuron(-5, 1, 0, 0, 0, 0, 0, 0, -1);
        neuron(127, 0, 0, 0, 0, 0, 0, 0, -1);
        // Partial neuron discarded by RST_MAC, then a full one with EN_MAC gaps.
        partial(2);
        neuron(1000, 3, 0, 1, 1, 0, 0, 0, -1);
        drain();

        // Overflow: five neurons into a four-deep FIFO, then push+pop at full.
        do_reset();
        rmode = 0;
        for (int n = 0; n < 5; n++) neuron(100 * n - 150, 1, 0, 0, 0, 0, 0, 0, -1);
        cyc();
        neuron(77, 0, 0, 0, 0, 0, 0, 0, 1);
        drain();

        // RST_ACT while a capture is pending and the FIFO holds entries.
        rmode = 0;
        neuron(40, 0, 0, 0, 0, 0, 0, 0, -1);
        neuron(-40, 0, 0, 0, 0, 0, 0, 0, -1);
        neuron(90, 0, 0, 0, 0, 0, 0, 1, -1);
        cyc();
        rmode = 1;
        neuron(12, 2, 0, 1, 0, 0, 0, 0, -1);
        drain();

        // Randomised traffic with random backpressure.
        rmode = 2;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 0) fin = int'($urandom_range(0, 600)) - 300;
            else fin = int'($urandom_range(0, 65535)) - 32768;
            if ($urandom_range(0, 7) == 0) partial($urandom_range(1, N_TERMS - 1));
            neuron(fin, int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                   1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0), 0, -1);
        end
        drain();
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
